// File: rtl/sd_arbiter_pkg.sv
// Shared definitions for the SD word-reader arbiter: FSM state encoding,
// bus widths, default timeout and the round-robin pointer width helper.
package sd_arbiter_pkg;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 2000000;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_START  = 3'd2,
    ST_WBUSY  = 3'd3,
    ST_WDATEN = 3'd4,
    ST_WIDLE  = 3'd5
  } state_t;

  // Pointer width; a single requester still needs a one-bit register.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//  Anfrage : request vector
//  ptr     : requester with highest priority this round
//  grant   : one-hot winner (all zero when nothing requested)
//  valid   : at least one request present
module rr_arbiter
  import sd_arbiter_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = ptr_width(N)
) (
  input  logic [N-1:0]  Anfrage,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  // First pass searches ptr..N-1, second pass wraps to 0..ptr-1.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid && Anfrage[i] && (i >= 32'(ptr))) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid && Anfrage[i] && (i < 32'(ptr))) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_lese_arbiter.sv
// Shares one SD-card word reader between N requesters with round-robin
// arbitration, per-phase timeout and per-requester ack/error pulses.
//  Clock, Reset                 : clock, async active-high reset
//  Anfrage, AnfrageAdresse      : level requests and their word addresses
//  Bestaetigung, Fehler         : one-cycle completion / timeout pulses
//  LeseDaten                    : last word read
//  Belegt, Zustand              : busy flag and FSM state for debug
//  SdAdresse, SdLesen           : address and read strobe to the reader
//  SdDaten, SdFertig, SdBusy    : reader response
module sd_lese_arbiter
  import sd_arbiter_pkg::*;
#(
  parameter int unsigned N       = 2,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned TW      = 22
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [N-1:0]        Anfrage,
  input  logic [ADDR_W*N-1:0] AnfrageAdresse,
  output logic [N-1:0]        Bestaetigung,
  output logic [N-1:0]        Fehler,
  output logic [DATA_W-1:0]   LeseDaten,
  output logic                Belegt,
  output logic [2:0]          Zustand,
  output logic [ADDR_W-1:0]   SdAdresse,
  output logic                SdLesen,
  input  logic [DATA_W-1:0]   SdDaten,
  input  logic                SdFertig,
  input  logic                SdBusy
);

  localparam int unsigned PW = ptr_width(N);

  state_t              state;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       gnt_idx;
  logic [TW-1:0]       cnt;
  logic [N-1:0]        win_oh;
  logic                win_v;
  logic [PW-1:0]       win_idx;
  logic [ADDR_W-1:0]   win_adr;
  logic [PW-1:0]       next_ptr;
  logic [N-1:0]        gnt_oh;
  logic                tmo;

  rr_arbiter #(.N(N)) u_rr (
    .Anfrage (Anfrage),
    .ptr     (ptr),
    .grant   (win_oh),
    .valid   (win_v)
  );

  // One-hot winner to index and address.
  always_comb begin
    win_idx = '0;
    win_adr = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win_oh[i]) begin
        win_idx = PW'(i);
        win_adr = AnfrageAdresse[ADDR_W*i +: ADDR_W];
      end
    end
  end

  assign next_ptr = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
  assign gnt_oh   = N'(1) << gnt_idx;
  assign tmo      = (cnt == TW'(TIMEOUT - 1));
  assign Zustand  = state;

  // Transaction FSM; the timeout counter is cleared on every state change.
  // A timeout also advances the pointer so a dead requester cannot starve others.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= ST_INIT;
      Belegt       <= 1'b1;
      SdLesen      <= 1'b0;
      SdAdresse    <= '0;
      LeseDaten    <= '0;
      Bestaetigung <= '0;
      Fehler       <= '0;
      ptr          <= '0;
      gnt_idx      <= '0;
      cnt          <= '0;
    end else begin
      SdLesen      <= 1'b0;
      Bestaetigung <= '0;
      Fehler       <= '0;
      case (state)
        ST_INIT: begin
          if (!SdBusy) begin
            state  <= ST_IDLE;
            Belegt <= 1'b0;
            cnt    <= '0;
          end
        end
        ST_IDLE: begin
          if (win_v && !SdBusy) begin
            SdAdresse <= win_adr;
            gnt_idx   <= win_idx;
            Belegt    <= 1'b1;
            SdLesen   <= 1'b1;
            state     <= ST_START;
            cnt       <= '0;
          end
        end
        ST_START: begin
          state <= ST_WBUSY;
          cnt   <= '0;
        end
        ST_WBUSY: begin
          if (SdBusy) begin
            state <= ST_WDATEN;
            cnt   <= '0;
          end else if (tmo) begin
            Fehler <= gnt_oh;
            ptr    <= next_ptr;
            state  <= ST_INIT;
            cnt    <= '0;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        ST_WDATEN: begin
          if (SdFertig) begin
            LeseDaten    <= SdDaten;
            Bestaetigung <= gnt_oh;
            state        <= ST_WIDLE;
            cnt          <= '0;
          end else if (tmo) begin
            Fehler <= gnt_oh;
            ptr    <= next_ptr;
            state  <= ST_INIT;
            cnt    <= '0;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        ST_WIDLE: begin
          if (!SdBusy && !SdFertig) begin
            state  <= ST_IDLE;
            Belegt <= 1'b0;
            ptr    <= next_ptr;
            cnt    <= '0;
          end else if (tmo) begin
            Fehler <= gnt_oh;
            ptr    <= next_ptr;
            state  <= ST_INIT;
            cnt    <= '0;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        default: begin
          state  <= ST_INIT;
          Belegt <= 1'b1;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule
